// File: rtl/apb_timer.sv
// apb_timer: APB slave countdown timer with a programmable prescaler,
// one-shot or auto-reload operation and a level interrupt.
//
// Handshake: a transfer is requested by PSEL with PENABLE low for one cycle,
// then PSEL and PENABLE held high with PADDR/PWRITE/PWDATA/PSTRB stable until
// the slave answers. PREADY is the slave's "valid" and is high for exactly one
// cycle (ACCESS). PRDATA and PSLVERR carry meaning only in that cycle and read
// as zero otherwise. A write commits on the clock edge that ends ACCESS.
module apb_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] PRDATA,
    output logic        IRQ,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_WAIT   = 2'd2,
        S_ACCESS = 2'd3
    } bus_state_t;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LOAD   = 5'h04;
    localparam logic [4:0] OFF_COUNT  = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_PRESC  = 5'h10;

    bus_state_t state, state_nxt;

    // Timer registers
    logic                  en, ar, ie;
    logic [31:0]           load;
    logic [31:0]           count;
    logic                  exp_flag;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] pcnt;

    // Address decode and request qualification
    logic [4:0]  offset;
    logic        addr_err;
    logic        req_err;
    logic        enter_access;
    logic [31:0] rdata_mux;
    logic        unused_addr;

    assign offset       = PADDR[4:0];
    assign unused_addr  = &{1'b0, PADDR[31:5]};
    assign addr_err     = (offset[1:0] != 2'b00) || (offset > OFF_PRESC);
    assign req_err      = addr_err || (PWRITE && (offset == OFF_COUNT));
    assign enter_access = (state == S_WAIT) && PSEL;
    assign dbg_state    = state;

    // Write strobes: only a non-erroring, non-empty write in ACCESS commits
    logic wr_ok, ctrl_wr, load_wr, stat_wr, presc_wr;

    assign wr_ok    = (state == S_ACCESS) && PSEL && PWRITE && !PSLVERR && (PSTRB != 4'b0000);
    assign ctrl_wr  = wr_ok && (offset == OFF_CTRL);
    assign load_wr  = wr_ok && (offset == OFF_LOAD);
    assign stat_wr  = wr_ok && (offset == OFF_STATUS);
    assign presc_wr = wr_ok && (offset == OFF_PRESC);

    // Byte-lane merged write values
    logic [31:0]           load_new;
    logic [PRESCALE_W-1:0] presc_new;
    logic [2:0]            ctrl_new;

    // Merge PWDATA into the current register contents under PSTRB
    always_comb begin
        load_new  = load;
        presc_new = presc;
        ctrl_new  = PSTRB[0] ? PWDATA[2:0] : {ie, ar, en};
        for (int b = 0; b < 4; b++) begin
            if (PSTRB[b]) load_new[8*b +: 8] = PWDATA[8*b +: 8];
        end
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (PSTRB[i >> 3]) presc_new[i] = PWDATA[i];
        end
    end

    // Tick generation; a LOAD write or an EN-clearing write overrides a tick
    logic tick, kill_tick, do_tick, expire;

    assign tick      = en && (pcnt == presc);
    assign kill_tick = load_wr || (ctrl_wr && !ctrl_new[0]);
    assign do_tick   = tick && !kill_tick;
    assign expire    = do_tick && (count == 32'd0);

    // Bus FSM state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Bus FSM next-state: SETUP -> WAIT -> ACCESS, abort to IDLE if PSEL drops
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (PSEL && !PENABLE) state_nxt = S_SETUP;
            S_SETUP: begin
                if (!PSEL)        state_nxt = S_IDLE;
                else if (PENABLE) state_nxt = S_WAIT;
            end
            S_WAIT:   state_nxt = PSEL ? S_ACCESS : S_IDLE;
            S_ACCESS: state_nxt = (PSEL && !PENABLE) ? S_SETUP : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Read mux over the register map
    always_comb begin
        rdata_mux = '0;
        case (offset)
            OFF_CTRL:   rdata_mux = {29'b0, ie, ar, en};
            OFF_LOAD:   rdata_mux = load;
            OFF_COUNT:  rdata_mux = count;
            OFF_STATUS: rdata_mux = {31'b0, exp_flag};
            OFF_PRESC:  rdata_mux = {{(32-PRESCALE_W){1'b0}}, presc};
            default:    rdata_mux = '0;
        endcase
    end

    // Registered response, captured on the edge entering ACCESS
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY  <= enter_access;
            PSLVERR <= enter_access && req_err;
            PRDATA  <= (enter_access && !PWRITE && !req_err) ? rdata_mux : 32'd0;
        end
    end

    // Configuration registers; a CTRL write takes priority over one-shot disable
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en    <= 1'b0;
            ar    <= 1'b0;
            ie    <= 1'b0;
            load  <= '0;
            presc <= '0;
        end else begin
            if (ctrl_wr)               {ie, ar, en} <= ctrl_new;
            else if (expire && !ar)    en <= 1'b0;
            if (load_wr)  load  <= load_new;
            if (presc_wr) presc <= presc_new;
        end
    end

    // Prescaler: counts while enabled, wraps on tick, cleared when stopped or reloaded
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                 pcnt <= '0;
        else if (!en || tick || kill_tick)            pcnt <= '0;
        else                                          pcnt <= pcnt + PRESCALE_W'(1);
    end

    // Down-counter: LOAD write copies in, tick decrements or reloads at zero
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)              count <= '0;
        else if (load_wr)          count <= load_new;
        else if (do_tick) begin
            if (count != 32'd0)    count <= count - 32'd1;
            else if (ar)           count <= load;
        end
    end

    // Expiry flag: set on expiry beats a simultaneous write-one-to-clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                   exp_flag <= 1'b0;
        else if (expire)                                exp_flag <= 1'b1;
        else if (stat_wr && PSTRB[0] && PWDATA[0])      exp_flag <= 1'b0;
    end

    // Interrupt output registered one cycle behind EXP & IE
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) IRQ <= 1'b0;
        else          IRQ <= exp_flag && ie;
    end

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed and randomized checks of apb_timer against a
// closed-form model of the countdown (ticks = elapsed / (PRESC+1)).
module tb_apb_timer;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_LOAD  = 32'h04;
  localparam logic [31:0] A_COUNT = 32'h08;
  localparam logic [31:0] A_STAT  = 32'h0C;
  localparam logic [31:0] A_PRESC = 32'h10;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic        PREADY, PSLVERR, IRQ;
  logic [31:0] PRDATA;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  // model of the running timer, anchored at edge m_e0
  int m_e0 = 0;
  int m_n = 0;
  int m_p = 0;
  bit m_ar = 0;
  bit m_ie = 0;
  bit m_exp0 = 0;

  apb_timer #(.PRESCALE_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA), .IRQ(IRQ),
    .dbg_state(dbg_state)
  );

  // clock and edge counter
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model: t = edges elapsed after m_e0
  function automatic int m_ticks(input int t);
    return t / (m_p + 1);
  endfunction

  function automatic logic [31:0] m_count(input int t);
    int k;
    k = m_ticks(t);
    if (m_ar) return 32'(m_n - (k % (m_n + 1)));
    return (k >= m_n) ? 32'd0 : 32'(m_n - k);
  endfunction

  function automatic bit m_exp(input int t);
    return m_exp0 || (m_ticks(t) >= m_n + 1);
  endfunction

  function automatic bit m_en(input int t);
    return m_ar || (m_ticks(t) < m_n + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one APB transfer; returns read data, error and the edge entering ACCESS
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, output logic [31:0] rd,
                     output logic err, output int acc_edge);
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 1;
    while (!PREADY && n < 6) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("latency", n, 3);
    acc_edge = cyc;
    rd = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'b0;
    chk("pready_drop", {31'b0, PREADY}, 32'd0);
  endtask

  task automatic wr_chk(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                        input logic exp_err, input string tag);
    logic [31:0] rd; logic err; int ae;
    apb(1'b1, addr, wd, strb, rd, err, ae);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic rd_const(input logic [31:0] addr, input logic [31:0] expv,
                          input logic exp_err, input string tag);
    logic [31:0] rd; logic err; int ae;
    exp_q.push_back(expv);
    apb(1'b0, addr, 32'd0, 4'hF, rd, err, ae);
    chk(tag, rd, exp_q.pop_front());
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  // read a timer register and compare against the model at the sample edge
  task automatic rd_model(input logic [31:0] addr, input string tag);
    logic [31:0] rd; logic err; int ae, t;
    apb(1'b0, addr, 32'd0, 4'h0, rd, err, ae);
    t = ae - 1 - m_e0;
    if (addr == A_COUNT)     exp_q.push_back(m_count(t));
    else if (addr == A_STAT) exp_q.push_back({31'b0, m_exp(t)});
    else                     exp_q.push_back({29'b0, m_ie, m_ar, m_en(t)});
    chk(tag, rd, exp_q.pop_front());
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  task automatic chk_irq(input string tag);
    int t;
    t = cyc - 1 - m_e0;
    chk(tag, {31'b0, IRQ}, {31'b0, m_ie && m_exp(t)});
  endtask

  task automatic start_timer(input int n, input int p, input bit ar, input bit ie);
    logic [31:0] rd; logic err; int ae;
    wr_chk(A_CTRL, 32'd0, 4'hF, 1'b0, "cfg_stop");
    wr_chk(A_STAT, 32'd1, 4'h1, 1'b0, "cfg_w1c");
    wr_chk(A_PRESC, 32'(p), 4'hF, 1'b0, "cfg_presc");
    wr_chk(A_LOAD, 32'(n), 4'hF, 1'b0, "cfg_load");
    apb(1'b1, A_CTRL, {29'b0, ie, ar, 1'b1}, 4'h1, rd, err, ae);
    chk("cfg_ctrl_err", {31'b0, err}, 32'd0);
    m_e0 = cyc; m_n = n; m_p = p; m_ar = ar; m_ie = ie; m_exp0 = 1'b0;
  endtask

  // stop the timer; the stopping write suppresses any tick on its edge
  task automatic stop_chk(input string tag);
    logic [31:0] rd; logic err; int ae, tw;
    logic [31:0] fc; logic fe;
    apb(1'b1, A_CTRL, 32'd0, 4'h1, rd, err, ae);
    tw = cyc - m_e0;
    fc = m_count(tw - 1);
    fe = m_exp(tw - 1);
    rd_const(A_COUNT, fc, 1'b0, {tag, "_count"});
    rd_const(A_STAT, {31'b0, fe}, 1'b0, {tag, "_exp"});
  endtask

  task automatic reload(input int nn);
    logic [31:0] rd; logic err; int ae, tw;
    apb(1'b1, A_LOAD, 32'(nn), 4'hF, rd, err, ae);
    chk("reload_err", {31'b0, err}, 32'd0);
    tw = cyc - m_e0;
    m_exp0 = m_exp(tw - 1);
    m_e0 = cyc;
    m_n = nn;
  endtask

  initial begin
    int n, p, nn; bit ar, ie;

    // reset state
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    for (int a = 0; a <= 16; a += 4) rd_const(32'(a), 32'd0, 1'b0, "rst_reg");

    // byte-lane merged LOAD write, copied into COUNT
    wr_chk(A_LOAD, 32'h12345678, 4'b0101, 1'b0, "strb_load");
    rd_const(A_LOAD, 32'h00340078, 1'b0, "strb_load_rd");
    rd_const(A_COUNT, 32'h00340078, 1'b0, "strb_count_rd");
    wr_chk(A_PRESC, 32'hABCDEF12, 4'hF, 1'b0, "presc_wide");
    rd_const(A_PRESC, 32'h00000012, 1'b0, "presc_mask");
    wr_chk(A_CTRL, 32'hFFFFFFF8, 4'hF, 1'b0, "ctrl_high");
    rd_const(A_CTRL, 32'd0, 1'b0, "ctrl_high_rd");

    // one-shot LOAD=3 PRESC=1 IE=1: EXP at +8, IRQ at +9
    start_timer(3, 1, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge PCLK); #1;
      chk("os_irq_edge", {31'b0, IRQ}, {31'b0, (cyc - m_e0) >= 9});
    end
    rd_const(A_CTRL, 32'h4, 1'b0, "os_ctrl");
    rd_const(A_COUNT, 32'd0, 1'b0, "os_count");
    rd_const(A_STAT, 32'd1, 1'b0, "os_exp");

    // randomized trials; trial 0 is LOAD=2 PRESC=0 CTRL=0x3
    for (int tr = 0; tr < 8; tr++) begin
      n  = (tr == 0) ? 2 : $urandom_range(0, 5);
      p  = (tr == 0) ? 0 : $urandom_range(0, 3);
      ar = (tr == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ie = (tr == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      start_timer(n, p, ar, ie);
      for (int r = 0; r < 4; r++) begin
        repeat ($urandom_range(0, 6)) begin @(posedge PCLK); #1; end
        rd_model(A_COUNT, "rnd_count");
        rd_model(A_STAT, "rnd_exp");
        rd_model(A_CTRL, "rnd_ctrl");
        chk_irq("rnd_irq");
        if (m_ar && r == 1) begin
          nn = $urandom_range(0, 5);
          reload(nn);
        end
      end
      stop_chk("rnd_stop");
    end

    // expiry every cycle vs W1C: set wins
    start_timer(0, 0, 1'b1, 1'b1);
    repeat (2) begin @(posedge PCLK); #1; end
    wr_chk(A_STAT, 32'd1, 4'h1, 1'b0, "w1c_race");
    rd_const(A_STAT, 32'd1, 1'b0, "w1c_race_rd");
    wr_chk(A_CTRL, 32'h4, 4'h1, 1'b0, "ie_only");
    @(posedge PCLK); #1;
    chk("irq_held", {31'b0, IRQ}, 32'd1);
    wr_chk(A_STAT, 32'd1, 4'h1, 1'b0, "w1c");
    rd_const(A_STAT, 32'd0, 1'b0, "w1c_rd");
    chk("irq_clr", {31'b0, IRQ}, 32'd0);

    // error responses change no state
    wr_chk(A_LOAD, 32'h55, 4'hF, 1'b0, "err_setup");
    rd_const(32'h14, 32'd0, 1'b1, "err_rd14");
    rd_const(32'h02, 32'd0, 1'b1, "err_rd02");
    wr_chk(A_COUNT, 32'hFFFFFFFF, 4'hF, 1'b1, "err_wr_count");
    rd_const(A_COUNT, 32'h55, 1'b0, "err_count_kept");
    wr_chk(32'h05, 32'hAA, 4'hF, 1'b1, "err_wr05");
    wr_chk(32'h18, 32'hAA, 4'hF, 1'b1, "err_wr18");
    wr_chk(A_LOAD, 32'hAA, 4'h0, 1'b0, "strb0_wr");
    rd_const(A_LOAD, 32'h55, 1'b0, "err_load_kept");

    // reset during WAIT with the timer running and IRQ high
    start_timer(0, 0, 1'b1, 1'b1);
    repeat (3) begin @(posedge PCLK); #1; end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_CTRL; PSTRB = 4'h0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk_irq("pre_rst_irq");
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_pready", {31'b0, PREADY}, 32'd0);
    chk("arst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("arst_prdata", PRDATA, 32'd0);
    chk("arst_irq", {31'b0, IRQ}, 32'd0);
    chk("arst_state", {30'b0, dbg_state}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    rd_const(A_CTRL, 32'd0, 1'b0, "post_rst_ctrl");
    rd_const(A_COUNT, 32'd0, 1'b0, "post_rst_count");
    rd_const(A_LOAD, 32'd0, 1'b0, "post_rst_load");
    rd_const(A_STAT, 32'd0, 1'b0, "post_rst_stat");
    rd_const(A_PRESC, 32'd0, 1'b0, "post_rst_presc");
    chk("post_rst_irq", {31'b0, IRQ}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
